db9_hid_encoder: RTL and testbench

Converts a physical Atari ST mouse or joystick on the local DB9 port into HID command frames on the strobe/start/data byte stream that the hid block consumes. Mouse mode decodes X/Y quadrature into signed deltas and emits CMD 2 frames. Joystick mode emits CMD 3 frames for device 0 on state change. The encoder sits between the DB9 input pins and the HID byte-stream mux, so local devices can drive the existing mouse and joystick paths.

---
 rtl/db9_hid_encoder.sv | 135 +++++++++++++
 tb/tb_db9_hid_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/db9_hid_encoder.sv
// db9_hid_encoder: turns a local Atari ST mouse or joystick on the DB9 pins into HID command frames on a strobe/start/data byte stream.
module db9_hid_encoder #(
  parameter logic [15:0] RATE_DIV = 16'd50000,
  parameter logic [3:0]  BYTE_GAP = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] db9_port,
  input  logic       mode,
  input  logic       out_ready,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, CMD, B1, B2, B3} state_t;

  state_t      state_q, state_d;
  logic [5:0]  s1_q, s_q;
  logic [1:0]  v_q;
  logic        primed_q, cur_mode_q;
  logic [1:0]  px_q, py_q;
  logic [7:0]  ax_q, ay_q, dx_q, dy_q;
  logic [1:0]  btn_sent_q;
  logic [4:0]  joy_sent_q;
  logic [15:0] rate_q;
  logic [3:0]  gap_q;
  logic [7:0]  data_q;

  logic [1:0] btn, dpx, dpy;
  logic [4:0] joy;
  logic       dec_en, inc_x, dec_x, inc_y, dec_y;
  logic       mode_chg, trig, launch, emit;
  logic [7:0] byte_d;

  // Gray position along the forward sequence 00->01->11->10
  function automatic logic [1:0] pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] a, input logic inc, input logic dec);
    return (inc && a != 8'h7f) ? a + 8'd1 : (dec && a != 8'h80) ? a - 8'd1 : a;
  endfunction

  always_comb begin
    btn      = ~s_q[5:4];
    joy      = ~s_q[4:0];
    dpx      = pos(s_q[1:0]) - pos(px_q);
    dpy      = pos(s_q[3:2]) - pos(py_q);
    dec_en   = v_q[1] && primed_q && !cur_mode_q;
    inc_x    = dec_en && dpx == 2'd1;
    dec_x    = dec_en && dpx == 2'd3;
    inc_y    = dec_en && dpy == 2'd1;
    dec_y    = dec_en && dpy == 2'd3;
    mode_chg = state_q == IDLE && mode != cur_mode_q;
    trig     = cur_mode_q ? joy != joy_sent_q
                          : (ax_q != 8'd0 || ay_q != 8'd0 || btn != btn_sent_q);
    launch   = state_q == IDLE && !mode_chg && v_q[1] && rate_q == 16'd0 && trig;
    emit     = state_q != IDLE && out_ready && gap_q == 4'd0;
    byte_d   = state_q == CMD ? {7'b0000001, cur_mode_q} :
               state_q == B1  ? (cur_mode_q ? 8'h00 : {6'b0, btn_sent_q}) :
               state_q == B2  ? (cur_mode_q ? {3'b0, joy_sent_q} : dx_q) :
               state_q == B3  ? dy_q : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = CMD;
      CMD:     if (emit) state_d = B1;
      B1:      if (emit) state_d = B2;
      B2:      if (emit) state_d = cur_mode_q ? IDLE : B3;
      B3:      if (emit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_out_strobe = emit;
  assign data_out_start  = emit && state_q == CMD;
  assign data_out        = emit ? byte_d : data_q;
  assign busy            = state_q != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= '1;
      s_q        <= '1;
      v_q        <= '0;
      primed_q   <= 1'b0;
      cur_mode_q <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      btn_sent_q <= '0;
      joy_sent_q <= '0;
      rate_q     <= '0;
      gap_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= db9_port;
      s_q     <= s1_q;
      v_q     <= {v_q[0], 1'b1};
      rate_q  <= launch ? RATE_DIV - 16'd1 : rate_q - {15'd0, rate_q != 16'd0};
      gap_q   <= emit ? BYTE_GAP - 4'd1 : gap_q - {3'd0, gap_q != 4'd0};
      if (emit) data_q <= byte_d;
      if (mode_chg) begin
        cur_mode_q <= mode;
        primed_q   <= 1'b0;
        ax_q       <= '0;
        ay_q       <= '0;
        btn_sent_q <= '0;
        joy_sent_q <= '0;
      end else begin
        if (v_q[1]) begin
          px_q     <= s_q[1:0];
          py_q     <= s_q[3:2];
          primed_q <= 1'b1;
        end
        // A step landing in the launch cycle seeds the freshly cleared accumulator
        ax_q <= sat(launch ? 8'd0 : ax_q, inc_x, dec_x);
        ay_q <= sat(launch ? 8'd0 : ay_q, inc_y, dec_y);
        if (launch) begin
          dx_q       <= ax_q;
          dy_q       <= ay_q;
          btn_sent_q <= btn;
          joy_sent_q <= joy;
        end
      end
    end
  end
endmodule

// File: tb/tb_db9_hid_encoder.sv
// tb_db9_hid_encoder: directed bench for the DB9-to-HID frame encoder.
module tb_db9_hid_encoder;
  localparam logic [15:0] RD = 16'd1000;
  localparam logic [3:0]  BG = 4'd4;

  logic       clk = 1'b0, reset = 1'b1, mode = 1'b0, out_ready = 1'b1;
  logic [5:0] db9 = 6'b110000;
  logic       strobe, start, busy;
  logic [7:0] dout;

  db9_hid_encoder #(.RATE_DIV(RD), .BYTE_GAP(BG)) dut (
    .clk(clk), .reset(reset), .db9_port(db9), .mode(mode), .out_ready(out_ready),
    .data_out_strobe(strobe), .data_out_start(start), .data_out(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic st; logic [7:0] d; int c;} ent_t;
  ent_t q[$];
  ent_t mon_e;
  int cyc = 0;
  int checks = 0, errors = 0;
  int fa, la, fb, lb, c1, c2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (strobe === 1'b1) begin
      mon_e.st = start;
      mon_e.d  = dout;
      mon_e.c  = cyc;
      q.push_back(mon_e);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_arrive"}, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int budget,
                              output int first, output int last);
    logic [7:0] e [4];
    e = '{b0, b1, b2, b3};
    first = -1;
    last  = -1;
    wait_bytes(tag, n, budget);
    if (q.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_start%0d", tag, i), 32'(q[i].st), 32'(i == 0));
        chk($sformatf("%s_byte%0d", tag, i), 32'(q[i].d), 32'(e[i]));
      end
      first = q[0].c;
      last  = q[n-1].c;
      repeat (n) void'(q.pop_front());
    end
  endtask

  function automatic logic [1:0] qstep(input logic [1:0] ba, input logic fwd);
    logic [1:0] f, r;
    f = ba == 2'b00 ? 2'b01 : ba == 2'b01 ? 2'b11 : ba == 2'b11 ? 2'b10 : 2'b00;
    r = ba == 2'b00 ? 2'b10 : ba == 2'b10 ? 2'b11 : ba == 2'b11 ? 2'b01 : 2'b00;
    return fwd ? f : r;
  endfunction

  task automatic stepx(input logic fwd, input int hold);
    db9[1:0] = qstep(db9[1:0], fwd);
    tick(hold);
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(1);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(20);
    chk("idle_quiet", 32'(q.size()), 32'd0);

    db9[4] = 1'b0;
    expect_frame("btn", 4, 8'h02, 8'h01, 8'h00, 8'h00, 50, fa, la);
    chk("frame_span", 32'(la - fa), 32'(3 * BG));
    db9[4] = 1'b1;
    repeat (5) stepx(1'b1, 20);
    expect_frame("x5", 4, 8'h02, 8'h00, 8'h05, 8'h00, 1200, fb, lb);
    chk("rate_min", 32'(fb - fa >= int'(RD)), 32'd1);

    repeat (200) stepx(1'b0, 4);
    expect_frame("xsat", 4, 8'h02, 8'h00, 8'h80, 8'h00, 400, fa, la);
    repeat (3) stepx(1'b0, 4);
    expect_frame("xafter", 4, 8'h02, 8'h00, 8'hFD, 8'h00, 1200, fa, la);

    tick(1000);
    db9[3:2] = 2'b11;
    tick(50);
    chk("illegal_quiet", 32'(q.size()), 32'd0);
    db9[3:2] = 2'b10;
    expect_frame("ylegal", 4, 8'h02, 8'h00, 8'h00, 8'h01, 50, fa, la);

    reset = 1'b1;
    mode  = 1'b1;
    db9   = 6'b111111;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("joy_quiet", 32'(q.size()), 32'd0);
    db9 = 6'b101110;
    expect_frame("joy_press", 3, 8'h03, 8'h00, 8'h11, 8'h00, 50, c1, la);
    db9 = 6'b111111;
    expect_frame("joy_release", 3, 8'h03, 8'h00, 8'h00, 8'h00, 1200, c2, la);
    chk("joy_rate_min", 32'(c2 - c1 >= int'(RD)), 32'd1);
    chk("joy_rate_prompt", 32'(c2 - c1 <= int'(RD) + 10), 32'd1);

    reset = 1'b1;
    mode  = 1'b0;
    db9   = 6'b110000;
    tick(3);
    reset = 1'b0;
    tick(10);
    db9[1:0] = 2'b01;
    wait_bytes("hold_b1", 2, 50);
    out_ready = 1'b0;
    tick(50);
    chk("hold_count", 32'(q.size()), 32'd2);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_strobe", 32'(strobe), 32'd0);
    chk("hold_data", 32'(dout), 32'd0);
    out_ready = 1'b1;
    expect_frame("ready", 4, 8'h02, 8'h00, 8'h01, 8'h00, 50, fa, la);
    tick(20);
    chk("ready_nodup", 32'(q.size()), 32'd0);

    db9[4] = 1'b0;
    wait_bytes("mid_b1", 2, 1200);
    reset = 1'b1;
    tick(1);
    chk("midrst_strobe", 32'(strobe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(dout), 32'd0);
    reset = 1'b0;
    q.delete();
    expect_frame("after_rst", 4, 8'h02, 8'h01, 8'h00, 8'h00, 50, fa, la);
    tick(20);
    chk("after_rst_quiet", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
